// File: rtl/munoc_axi4_to_moi_slave_bridge_if.sv
// AXI4 slave-side and MOI request/response bundle for the
// slave bridge endpoint of the MOI-over-NoC path.
interface munoc_axi4_to_moi_slave_bridge_if #(
   parameter int BW_ADDR    = 32,
   parameter int BW_DATA    = 32,
   parameter int BW_AXI_TID = 4
);
   logic [BW_AXI_TID-1:0] sx4awid;
   logic [BW_ADDR-1:0]    sx4awaddr;
   logic [7:0]            sx4awlen;
   logic [2:0]            sx4awsize;
   logic [1:0]            sx4awburst;
   logic                  sx4awvalid;
   logic                  sx4awready;

   logic [BW_DATA-1:0]    sx4wdata;
   logic [BW_DATA/8-1:0]  sx4wstrb;
   logic                  sx4wlast;
   logic                  sx4wvalid;
   logic                  sx4wready;

   logic [BW_AXI_TID-1:0] sx4bid;
   logic [1:0]            sx4bresp;
   logic                  sx4bvalid;
   logic                  sx4bready;

   logic [BW_AXI_TID-1:0] sx4arid;
   logic [BW_ADDR-1:0]    sx4araddr;
   logic [7:0]            sx4arlen;
   logic [2:0]            sx4arsize;
   logic [1:0]            sx4arburst;
   logic                  sx4arvalid;
   logic                  sx4arready;

   logic [BW_AXI_TID-1:0] sx4rid;
   logic [BW_DATA-1:0]    sx4rdata;
   logic [1:0]            sx4rresp;
   logic                  sx4rlast;
   logic                  sx4rvalid;
   logic                  sx4rready;

   logic                  mqvalid;
   logic                  mqready;
   logic [BW_ADDR-1:0]    mqaddr;
   logic                  mqwrite;
   logic [BW_DATA-1:0]    mqwdata;
   logic [BW_DATA/8-1:0]  mqwpermit;

   logic                  myvalid;
   logic                  myready;
   logic [BW_DATA-1:0]    myrdata;

   // Bridge view: AXI slave, MOI master.
   modport slave (
      input  sx4awid, sx4awaddr, sx4awlen, sx4awsize, sx4awburst,
      input  sx4awvalid,
      output sx4awready,
      input  sx4wdata, sx4wstrb, sx4wlast, sx4wvalid,
      output sx4wready,
      output sx4bid, sx4bresp, sx4bvalid,
      input  sx4bready,
      input  sx4arid, sx4araddr, sx4arlen, sx4arsize, sx4arburst,
      input  sx4arvalid,
      output sx4arready,
      output sx4rid, sx4rdata, sx4rresp, sx4rlast, sx4rvalid,
      input  sx4rready,
      output mqvalid, mqaddr, mqwrite, mqwdata, mqwpermit,
      input  mqready,
      input  myvalid, myrdata,
      output myready
   );

   // Environment view: network interface plus local memory.
   modport master (
      output sx4awid, sx4awaddr, sx4awlen, sx4awsize, sx4awburst,
      output sx4awvalid,
      input  sx4awready,
      output sx4wdata, sx4wstrb, sx4wlast, sx4wvalid,
      input  sx4wready,
      input  sx4bid, sx4bresp, sx4bvalid,
      output sx4bready,
      output sx4arid, sx4araddr, sx4arlen, sx4arsize, sx4arburst,
      output sx4arvalid,
      input  sx4arready,
      input  sx4rid, sx4rdata, sx4rresp, sx4rlast, sx4rvalid,
      output sx4rready,
      input  mqvalid, mqaddr, mqwrite, mqwdata, mqwpermit,
      output mqready,
      output myvalid, myrdata,
      input  myready
   );
endinterface

// File: rtl/munoc_axi4_to_moi_slave_bridge.sv
// Replays AXI4 bursts as single-beat MOI requests, one
// transaction at a time, with round-robin AW/AR arbitration.
module munoc_axi4_to_moi_slave_bridge #(
   parameter int BW_ADDR         = 32,
   parameter int BW_DATA         = 32,
   parameter int BW_AXI_TID      = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic clk,
   input  logic rst,
   munoc_axi4_to_moi_slave_bridge_if.slave bus,
   output logic err_unexpected
);

   typedef enum logic [1:0] {IDLE, WRITE, BRESP, READ} state_t;

   state_t st;
   logic                  last_rd;
   logic                  awready_q;
   logic                  arready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;
   logic                  werr;
   logic                  rsv;
   logic                  wrap_en;
   logic                  err_q;
   logic [BW_AXI_TID-1:0] id_q;
   logic [BW_ADDR-1:0]    addr_q;
   logic [BW_ADDR-1:0]    base_q;
   logic [BW_ADDR-1:0]    mask_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [8:0]            beat_q;
   logic [7:0]            ret_q;
   logic [3:0]            out_q;

   logic                  aw_hs;
   logic                  ar_hs;
   logic                  mq_hs;
   logic                  r_hs;
   logic                  rd_issue;
   logic                  w_bad;
   logic                  werr_n;
   logic                  last_beat;
   logic [BW_ADDR-1:0]    step;
   logic [BW_ADDR-1:0]    nxt_addr;
   logic [BW_ADDR-1:0]    lat_addr;
   logic [BW_ADDR-1:0]    lat_mask;
   logic [7:0]            lat_len;
   logic [2:0]            lat_size;
   logic [1:0]            lat_burst;
   logic                  lat_wrap;

   assign aw_hs = bus.sx4awvalid & awready_q;
   assign ar_hs = bus.sx4arvalid & arready_q;

   // Select the address channel being accepted and size its wrap window.
   always_comb begin
      lat_addr  = aw_hs ? bus.sx4awaddr  : bus.sx4araddr;
      lat_len   = aw_hs ? bus.sx4awlen   : bus.sx4arlen;
      lat_size  = aw_hs ? bus.sx4awsize  : bus.sx4arsize;
      lat_burst = aw_hs ? bus.sx4awburst : bus.sx4arburst;
      lat_mask  = ((BW_ADDR'(lat_len) + BW_ADDR'(1)) << lat_size)
                  - BW_ADDR'(1);
      lat_wrap  = (lat_burst == 2'b10) &&
                  (lat_len == 8'd1 || lat_len == 8'd3 ||
                   lat_len == 8'd7 || lat_len == 8'd15);
   end

   // Next beat address; illegal WRAP lengths and reserved bursts step as INCR.
   always_comb begin
      step     = BW_ADDR'(1) << size_q;
      nxt_addr = addr_q + step;
      if (burst_q == 2'b00)
         nxt_addr = addr_q;
      else if (wrap_en)
         nxt_addr = base_q | ((addr_q + step) & mask_q);
   end

   assign last_beat = (beat_q == {1'b0, len_q});
   assign rd_issue  = (st == READ) && (beat_q <= {1'b0, len_q}) &&
                      (out_q < 4'(MAX_OUTSTANDING));
   assign w_bad     = bus.sx4wlast ? (beat_q < {1'b0, len_q}) : last_beat;
   assign werr_n    = werr | w_bad;

   assign bus.mqvalid   = ((st == WRITE) & bus.sx4wvalid) | rd_issue;
   assign bus.mqaddr    = addr_q;
   assign bus.mqwrite   = (st == WRITE);
   assign bus.mqwdata   = (st == WRITE) ? bus.sx4wdata : '0;
   assign bus.mqwpermit = (st == WRITE) ? bus.sx4wstrb : '0;
   assign bus.sx4wready = (st == WRITE) & bus.mqready;
   assign mq_hs         = bus.mqvalid & bus.mqready;

   assign bus.sx4awready = awready_q;
   assign bus.sx4arready = arready_q;
   assign bus.sx4bvalid  = bvalid_q;
   assign bus.sx4bresp   = bresp_q;
   assign bus.sx4bid     = id_q;

   assign bus.sx4rvalid = (st == READ) & bus.myvalid;
   assign bus.sx4rdata  = bus.myrdata;
   assign bus.sx4rid    = id_q;
   assign bus.sx4rresp  = rsv ? 2'b10 : 2'b00;
   assign bus.sx4rlast  = (st == READ) && (ret_q == len_q);
   assign bus.myready   = (st == READ) ? bus.sx4rready : 1'b1;
   assign r_hs          = bus.sx4rvalid & bus.sx4rready;

   assign err_unexpected = err_q;

   // Transaction FSM: arbitration, burst bookkeeping and B generation.
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         last_rd   <= 1'b1;
         awready_q <= 1'b0;
         arready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         werr      <= 1'b0;
         rsv       <= 1'b0;
         wrap_en   <= 1'b0;
         err_q     <= 1'b0;
         id_q      <= '0;
         addr_q    <= '0;
         base_q    <= '0;
         mask_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         beat_q    <= '0;
         ret_q     <= '0;
         out_q     <= '0;
      end else begin
         awready_q <= 1'b0;
         arready_q <= 1'b0;
         if (st != READ && bus.myvalid)
            err_q <= 1'b1;
         case (st)
            IDLE: begin
               if (aw_hs || ar_hs) begin
                  id_q    <= aw_hs ? bus.sx4awid : bus.sx4arid;
                  addr_q  <= lat_addr;
                  base_q  <= lat_addr & ~lat_mask;
                  mask_q  <= lat_mask;
                  len_q   <= lat_len;
                  size_q  <= lat_size;
                  burst_q <= lat_burst;
                  wrap_en <= lat_wrap;
                  rsv     <= (lat_burst == 2'b11);
                  werr    <= (lat_burst == 2'b11);
                  beat_q  <= '0;
                  ret_q   <= '0;
                  out_q   <= '0;
                  last_rd <= ar_hs;
                  st      <= aw_hs ? WRITE : READ;
               end else if (!awready_q && !arready_q) begin
                  if (bus.sx4awvalid && (!bus.sx4arvalid || last_rd))
                     awready_q <= 1'b1;
                  else if (bus.sx4arvalid)
                     arready_q <= 1'b1;
               end
            end
            WRITE: begin
               if (mq_hs) begin
                  beat_q <= beat_q + 9'd1;
                  addr_q <= nxt_addr;
                  werr   <= werr_n;
                  if (last_beat) begin
                     bvalid_q <= 1'b1;
                     bresp_q  <= werr_n ? 2'b10 : 2'b00;
                     st       <= BRESP;
                  end
               end
            end
            BRESP: begin
               if (bus.sx4bready) begin
                  bvalid_q <= 1'b0;
                  bresp_q  <= 2'b00;
                  st       <= IDLE;
               end
            end
            READ: begin
               if (mq_hs) begin
                  beat_q <= beat_q + 9'd1;
                  addr_q <= nxt_addr;
               end
               out_q <= out_q + {3'b0, mq_hs} - {3'b0, r_hs};
               if (r_hs) begin
                  ret_q <= ret_q + 8'd1;
                  if (bus.sx4rlast)
                     st <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_munoc_axi4_to_moi_slave_bridge.sv
// Directed bench for the AXI4-to-MOI slave bridge with a
// 2-cycle-latency memory model and handshake monitors.
module tb_munoc_axi4_to_moi_slave_bridge;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TW = 4;
   localparam logic [31:0] K = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err_unexpected;
   always #5 clk = ~clk;

   munoc_axi4_to_moi_slave_bridge_if #(
      .BW_ADDR(AW), .BW_DATA(DW), .BW_AXI_TID(TW)
   ) bus ();

   munoc_axi4_to_moi_slave_bridge #(
      .BW_ADDR(AW), .BW_DATA(DW), .BW_AXI_TID(TW), .MAX_OUTSTANDING(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .err_unexpected(err_unexpected)
   );

   int n_run = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   logic mem_en = 1'b1;
   logic mem_valid = 1'b0;
   logic [31:0] mem_data = '0;
   logic man_valid = 1'b0;
   assign bus.myvalid = mem_en ? mem_valid : man_valid;
   assign bus.myrdata = mem_en ? mem_data : 32'h0;

   typedef struct {logic [31:0] a; logic w; logic [31:0] d; logic [3:0] p;} mq_t;
   typedef struct {logic [31:0] d; logic l; logic [1:0] r; logic [3:0] id;} r_t;
   typedef struct {logic [31:0] a; int due;} pend_t;
   mq_t mlog[$];
   r_t rlog[$];
   pend_t pq[$];
   int ocnt = 0;
   int omax = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   // Handshake monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mqvalid && bus.mqready)
            mlog.push_back('{bus.mqaddr, bus.mqwrite, bus.mqwdata, bus.mqwpermit});
         if (bus.sx4rvalid && bus.sx4rready)
            rlog.push_back('{bus.sx4rdata, bus.sx4rlast, bus.sx4rresp, bus.sx4rid});
         ocnt = ocnt + int'(bus.mqvalid && bus.mqready && !bus.mqwrite)
                     - int'(bus.sx4rvalid && bus.sx4rready);
         if (ocnt > omax) omax = ocnt;
      end
   end

   // Memory: each read answers 2 cycles after its request, in order.
   initial begin : memory
      logic hq, hy;
      logic [31:0] qa;
      forever begin
         @(negedge clk);
         hq = bus.mqvalid && bus.mqready && !bus.mqwrite;
         qa = bus.mqaddr;
         hy = mem_en && bus.myvalid && bus.myready;
         @(posedge clk);
         #1;
         if (hy && pq.size() > 0) void'(pq.pop_front());
         if (hq) pq.push_back('{qa, cyc + 2});
         mem_valid = (pq.size() > 0) && (pq[0].due <= cyc);
         mem_data  = mem_valid ? (pq[0].a ^ K) : 32'h0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [1:0] bu,
                          output int k);
      bus.sx4awid = id; bus.sx4awaddr = a; bus.sx4awlen = len;
      bus.sx4awsize = 3'd2; bus.sx4awburst = bu; bus.sx4awvalid = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.sx4awready) break;
      end
      chk("aw_accept", 64'(k < 20), 64'd1);
      tick();
      bus.sx4awvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] a,
                          input logic [7:0] len, input logic [1:0] bu);
      int k;
      bus.sx4arid = id; bus.sx4araddr = a; bus.sx4arlen = len;
      bus.sx4arsize = 3'd2; bus.sx4arburst = bu; bus.sx4arvalid = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.sx4arready) break;
      end
      chk("ar_accept", 64'(k < 20), 64'd1);
      tick();
      bus.sx4arvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic last);
      int k;
      bus.sx4wdata = d; bus.sx4wstrb = 4'hF; bus.sx4wlast = last;
      bus.sx4wvalid = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.sx4wready) break;
      end
      chk("w_accept", 64'(k < 20), 64'd1);
      tick();
      bus.sx4wvalid = 1'b0;
   endtask

   task automatic wait_b(input logic [3:0] id, input logic [1:0] resp,
                         output int k);
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.sx4bvalid) break;
      end
      chk("b_seen", 64'(k < 20), 64'd1);
      chk("bid", 64'(bus.sx4bid), 64'(id));
      chk("bresp", 64'(bus.sx4bresp), 64'(resp));
      tick();
   endtask

   task automatic wait_r(input int n);
      int k;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rlog.size() >= n) break;
      end
      chk("r_count", 64'(rlog.size()), 64'(n));
      tick();
   endtask

   task automatic wait_grant();
      int k;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.sx4awready || bus.sx4arready) break;
      end
      chk("grant_seen", 64'(k < 20), 64'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_awready"}, 64'(bus.sx4awready), 64'd0);
      chk({tag, "_arready"}, 64'(bus.sx4arready), 64'd0);
      chk({tag, "_bvalid"}, 64'(bus.sx4bvalid), 64'd0);
      chk({tag, "_mqvalid"}, 64'(bus.mqvalid), 64'd0);
      chk({tag, "_rvalid"}, 64'(bus.sx4rvalid), 64'd0);
      chk({tag, "_err"}, 64'(err_unexpected), 64'd0);
   endtask

   initial begin : main
      int k;
      logic [31:0] d0;
      bus.sx4awid = '0; bus.sx4awaddr = '0; bus.sx4awlen = '0;
      bus.sx4awsize = '0; bus.sx4awburst = '0; bus.sx4awvalid = 1'b0;
      bus.sx4wdata = '0; bus.sx4wstrb = '0; bus.sx4wlast = 1'b0;
      bus.sx4wvalid = 1'b0; bus.sx4bready = 1'b1;
      bus.sx4arid = '0; bus.sx4araddr = '0; bus.sx4arlen = '0;
      bus.sx4arsize = '0; bus.sx4arburst = '0; bus.sx4arvalid = 1'b0;
      bus.sx4rready = 1'b1; bus.mqready = 1'b1;

      repeat (3) tick();
      @(negedge clk);
      check_idle_outputs("reset");
      tick();
      rst = 1'b0;

      // Single write.
      mlog.delete();
      send_aw(4'd3, 32'h100, 8'd0, 2'b01, k);
      chk("t1_aw_latency", 64'(k), 64'd1);
      send_w(32'hDEAD_BEEF, 1'b1);
      wait_b(4'd3, 2'b00, k);
      chk("t1_b_latency", 64'(k), 64'd0);
      chk("t1_mq_count", 64'(mlog.size()), 64'd1);
      if (mlog.size() > 0) begin
         chk("t1_mq_addr", 64'(mlog[0].a), 64'h100);
         chk("t1_mq_write", 64'(mlog[0].w), 64'd1);
         chk("t1_mq_wdata", 64'(mlog[0].d), 64'hDEAD_BEEF);
         chk("t1_mq_permit", 64'(mlog[0].p), 64'hF);
      end

      // INCR read burst with 2 outstanding.
      mlog.delete(); rlog.delete(); ocnt = 0; omax = 0;
      send_ar(4'd5, 32'h200, 8'd3, 2'b01);
      wait_r(4);
      chk("t2_mq_count", 64'(mlog.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < mlog.size())
            chk("t2_mq_addr", 64'(mlog[i].a), 64'(32'h200 + 4 * i));
         if (i < rlog.size()) begin
            chk("t2_rdata", 64'(rlog[i].d), 64'((32'h200 + 4 * i) ^ K));
            chk("t2_rlast", 64'(rlog[i].l), 64'(i == 3));
            chk("t2_rid", 64'(rlog[i].id), 64'd5);
         end
      end
      chk("t2_max_outstanding", 64'(omax), 64'd2);

      // WRAP read.
      mlog.delete(); rlog.delete();
      send_ar(4'd1, 32'h38, 8'd3, 2'b10);
      wait_r(4);
      begin
         logic [31:0] wa [4];
         wa = '{32'h38, 32'h3C, 32'h30, 32'h34};
         for (int i = 0; i < 4; i++)
            if (i < mlog.size())
               chk("t3_wrap_addr", 64'(mlog[i].a), 64'(wa[i]));
      end

      // Ties: write wins out of reset, read wins the next one.
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      mlog.delete(); rlog.delete();
      bus.sx4awid = 4'd2; bus.sx4awaddr = 32'h40; bus.sx4awlen = 8'd1;
      bus.sx4awsize = 3'd2; bus.sx4awburst = 2'b01; bus.sx4awvalid = 1'b1;
      bus.sx4arid = 4'd7; bus.sx4araddr = 32'h80; bus.sx4arlen = 8'd0;
      bus.sx4arsize = 3'd2; bus.sx4arburst = 2'b01; bus.sx4arvalid = 1'b1;
      wait_grant();
      chk("t4_tie1_awready", 64'(bus.sx4awready), 64'd1);
      chk("t4_tie1_arready", 64'(bus.sx4arready), 64'd0);
      tick();
      bus.sx4awid = 4'd4; bus.sx4awaddr = 32'h60; bus.sx4awlen = 8'd0;
      send_w(32'h11, 1'b0);
      send_w(32'h22, 1'b1);
      wait_b(4'd2, 2'b00, k);
      wait_grant();
      chk("t4_tie2_arready", 64'(bus.sx4arready), 64'd1);
      chk("t4_tie2_awready", 64'(bus.sx4awready), 64'd0);
      tick();
      bus.sx4arvalid = 1'b0;
      wait_r(1);
      if (rlog.size() > 0)
         chk("t4_rdata", 64'(rlog[0].d), 64'(32'h80 ^ K));
      wait_grant();
      chk("t4_aw2_awready", 64'(bus.sx4awready), 64'd1);
      tick();
      bus.sx4awvalid = 1'b0;
      send_w(32'h33, 1'b1);
      wait_b(4'd4, 2'b00, k);
      if (mlog.size() > 2)
         chk("t4_order_third_is_read", 64'(mlog[2].w), 64'd0);

      // Early wlast, then a stray MOI response in IDLE.
      mlog.delete();
      send_aw(4'd6, 32'h300, 8'd3, 2'b01, k);
      send_w(32'hA0, 1'b0);
      send_w(32'hA1, 1'b1);
      send_w(32'hA2, 1'b0);
      send_w(32'hA3, 1'b1);
      wait_b(4'd6, 2'b10, k);
      chk("t5_mq_count", 64'(mlog.size()), 64'd4);
      if (mlog.size() > 3)
         chk("t5_last_addr", 64'(mlog[3].a), 64'h30C);
      chk("t5_err_before", 64'(err_unexpected), 64'd0);
      mem_en = 1'b0;
      man_valid = 1'b1;
      tick();
      man_valid = 1'b0;
      @(negedge clk);
      chk("t5_err_after", 64'(err_unexpected), 64'd1);
      tick();
      mem_en = 1'b1;

      // R backpressure, then reset mid-read.
      rst = 1'b1; tick(); rst = 1'b0;
      bus.sx4rready = 1'b0;
      send_ar(4'd9, 32'h400, 8'd1, 2'b01);
      for (k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.sx4rvalid) break;
      end
      chk("t6_rvalid_seen", 64'(k < 30), 64'd1);
      d0 = bus.sx4rdata;
      chk("t6_rdata", 64'(d0), 64'(32'h400 ^ K));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t6_myready_low", 64'(bus.myready), 64'd0);
         chk("t6_rvalid_held", 64'(bus.sx4rvalid), 64'd1);
         chk("t6_rdata_stable", 64'(bus.sx4rdata), 64'(d0));
      end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("t6_after_rst");
      @(negedge clk);
      chk("t6_inflight_err", 64'(err_unexpected), 64'd1);
      bus.sx4rready = 1'b1;
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
